sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation search driven by an external
// comparator. One trial bit is resolved per TRIAL cycle, MSB first,
// with an early exit on equality and an error exit on an illegal code.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IW-1:0]    idx_m1;
  logic             code_ok;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    idx_m1   = idx_q - IW'(1);
    code_ok  = $onehot({cmp_gt, cmp_lt, cmp_eq});

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d            = TRIAL;
          trial_d            = '0;
          trial_d[WIDTH-1]   = 1'b1;
          idx_d              = IW'(WIDTH - 1);
          busy_d             = 1'b1;
          err_d              = 1'b0;
        end
      end

      TRIAL: begin
        if (!code_ok) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = FINISH;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (cmp_eq) begin
          result_d = trial_q;
          state_d  = FINISH;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (idx_q == '0) begin
          result_d    = trial_q;
          result_d[0] = cmp_gt;
          state_d     = FINISH;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          // keep the bit if target is above the trial, drop it otherwise
          trial_d[idx_q]  = cmp_gt;
          trial_d[idx_m1] = 1'b1;
          idx_d           = idx_m1;
        end
      end

      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
